conv_mem_arbiter: RTL and testbench
===================================

Name: conv_mem_arbiter

Overview:
Shares one single-port, 1-cycle-latency SRAM between the convolution engine's three memory clients:
- requester 0: weight fetch (read)
- requester 1: image/FIB fetch (read)
- requester 2: output writeback (write)

Arbitration is round-robin with an optional bounded burst lock. Read data is routed back to the requester that issued the read via a per-requester valid. The block sits between the convolution controller's memory ports and the physical memory macro.

Parameters:
N_REQ, 3, number of requesters (2..8)
AW, 32, address width
DW, 32, data width
MAX_BURST, 8, maximum consecutive grants to one locked requester (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req  in  N_REQ  per-requester access request
req_we  in  N_REQ  per-requester write enable (1=write, 0=read)
req_lock  in  N_REQ  per-requester burst-lock request
req_addr  in  N_REQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  in  N_REQ*DW  packed write data
gnt  out  N_REQ  one-hot grant, same cycle as request
rvalid  out  N_REQ  one-hot read-return valid
rdata  out  DW  read return data (mem_rdata passthrough)
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid 1 cycle after a read issue
busy  out  1  high when any gnt or rvalid is high

Behaviour:
- Single clock domain. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values:
  - rr_ptr = N_REQ-1, so requester 0 has highest priority first.
  - lock_owner invalid; burst_cnt = 0; rvalid = 0.
  - While rst_n is low: gnt = 0, mem_en = 0, mem_we = 0, busy = 0.
- Grant is combinational:
  - If a lock is active and the owner still asserts req, the owner wins.
  - Otherwise the first asserted req scanning from rr_ptr+1 upward, modulo N_REQ, wins.
  - At most one gnt bit is high. No req means gnt = 0 and mem_en = 0.
- Memory drive:
  - mem_en = |gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted requester; they are 0 when nothing is granted.
  - A requester samples gnt and treats its request as consumed that cycle (no back-pressure beyond gnt).
- Read return:
  - A granted read (req_we=0) sets rvalid[i] on the next cycle. rvalid is registered.
  - rdata = mem_rdata combinationally.
  - Writes never raise rvalid.
  - Back-to-back reads from different requesters produce back-to-back single-cycle rvalid pulses in issue order.
- Pointer update: on any grant, rr_ptr <= granted index, including locked grants.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED when the granted requester has req_lock=1 and MAX_BURST>1. lock_owner is set to that requester and burst_cnt <= 1.
  - In LOCKED, each owner grant increments burst_cnt.
  - LOCKED -> UNLOCKED when the owner drops req or req_lock, or when a grant makes burst_cnt reach MAX_BURST.
  - On leaving LOCKED at the burst limit, the next arbitration is round-robin from rr_ptr = owner. Other requesters therefore take precedence, and starvation is bounded to MAX_BURST cycles.
  - If the owner deasserts req, the same cycle's arbitration is round-robin (no idle bubble).
- Simultaneous events: a new lock request by a non-owner is ignored while LOCKED. It is honoured only when that requester later wins round-robin with req_lock high.
- Reset mid-operation:
  - A pending rvalid is cleared and not delivered.
  - The lock is dropped and rr_ptr is restored.
  - The memory read in flight is discarded.
- Width rules: burst_cnt is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST. rr_ptr is $clog2(N_REQ) bits and wraps N_REQ-1 -> 0.

Test Plan:
1. Single read: req=001, we=0, addr=0x10, mem returns 0xCAFE -> gnt=001 same cycle, mem_en=1, mem_addr=0x10; next cycle rvalid=001, rdata=0xCAFE.
2. Contention: req=111 held 6 cycles, no lock -> grant order 0,1,2,0,1,2; rvalid follows each read one cycle later; requester 2 writes show mem_we=1 and never rvalid.
3. Burst lock: req0 lock=1 held 12 cycles, req1 held high -> gnt0 cycles 0-7, gnt1 cycle 8, gnt0 cycle 9 (new lock).
4. Early unlock: req0 locked, drops req_lock after 3 grants while req2 waiting -> gnt2 on the cycle req_lock falls; no idle cycle.
5. Reset mid-read: read granted at cycle N, rst_n=0 at edge N+1 -> rvalid=0 at N+1; after release, req=110 -> gnt=010 (requester 1 first eligible from ptr=2 with req0 low).
6. Idle: req=000 for 5 cycles -> gnt=0, mem_en=0, busy=0, rr_ptr unchanged.

Source files
------------

// File: rtl/conv_mem_arbiter.sv
// Round-robin arbiter with bounded burst lock, sharing one single-port SRAM
// (1-cycle read latency) between the convolution engine's memory clients.
module conv_mem_arbiter #(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ-1:0]    req_lock,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic                busy
);

    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [PW-1:0] PtrReset = PW'(N_REQ - 1);
    localparam logic [BW-1:0] BurstMax = BW'(MAX_BURST);

    typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;

    lock_state_e state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [BW-1:0] cnt_inc;
    logic [N_REQ-1:0] rvalid_q, rvalid_d;

    logic          rr_valid;
    logic [PW-1:0] rr_idx;
    logic [PW-1:0] cand;
    logic          lock_hold;
    logic          gnt_valid;
    logic [PW-1:0] gnt_idx;

    // Round-robin pick: scan downward so the nearest requester after rr_ptr wins last.
    always_comb begin
        rr_valid = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = int'(N_REQ); i >= 1; i--) begin
            cand = PW'((int'(rr_ptr_q) + i) % int'(N_REQ));
            if (req[cand]) begin
                rr_valid = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Grant selection: a live lock owner beats round-robin; nothing granted in reset.
    always_comb begin
        lock_hold = (state_q == StLocked) && req[owner_q] && req_lock[owner_q];
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (!rst_n) begin
            gnt_valid = 1'b0;
        end else if (lock_hold) begin
            gnt_valid = 1'b1;
            gnt_idx   = owner_q;
        end else if (rr_valid) begin
            gnt_valid = 1'b1;
            gnt_idx   = rr_idx;
        end
    end

    // Memory drive muxed from the granted requester; zero when idle.
    always_comb begin
        gnt       = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
            mem_we       = req_we[gnt_idx];
            mem_addr     = req_addr[gnt_idx*AW +: AW];
            mem_wdata    = req_wdata[gnt_idx*DW +: DW];
        end
        mem_en = gnt_valid;
        rdata  = mem_rdata;
        rvalid = rvalid_q & {N_REQ{rst_n}};
        busy   = rst_n & ((|gnt) | (|rvalid_q));
    end

    // Lock FSM, pointer and read-return next state.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        cnt_inc     = (burst_cnt_q == BurstMax) ? burst_cnt_q : burst_cnt_q + 1'b1;
        rr_ptr_d    = gnt_valid ? gnt_idx : rr_ptr_q;
        rvalid_d    = gnt & ~req_we;
        unique case (state_q)
            StUnlocked: begin
                // A lock only starts from round-robin, so non-owners wait their turn.
                if (gnt_valid && req_lock[gnt_idx] && (MAX_BURST > 1)) begin
                    state_d     = StLocked;
                    owner_d     = gnt_idx;
                    burst_cnt_d = BW'(1);
                end
            end
            StLocked: begin
                if (lock_hold) begin
                    if (cnt_inc == BurstMax) begin
                        state_d     = StUnlocked;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = cnt_inc;
                    end
                end else begin
                    state_d     = StUnlocked;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = StUnlocked;
                burst_cnt_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StUnlocked;
            rr_ptr_q    <= PtrReset;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed bench for conv_mem_arbiter with a small behavioural SRAM model.
module tb_conv_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    conv_mem_arbiter #(
        .N_REQ    (N),
        .AW       (AW),
        .DW       (DW),
        .MAX_BURST(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_we   (req_we),
        .req_lock (req_lock),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0000_CAFE : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [N-1:0] one_hot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] addr_of(input int i);
        return 32'h100 * (i + 1);
    endfunction

    // SRAM model: read data appears one cycle after a read issue.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addrs();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = addr_of(i);
            req_wdata[i*DW +: DW] = 32'hD00D_0000 + i;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '1;
        req_lock = '0;
        req_we = '0;
        tick();
        tick();
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_busy", busy, 0);
        check("rst_rvalid", rvalid, 0);
        tick();
        rst_n = 1'b1;
        req = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1);
    end

    initial begin
        int prev;
        int exp2 [6];
        logic [N-1:0] exp3 [12];

        exp2 = '{0, 1, 2, 0, 1, 2};
        exp3 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                 3'b010, 3'b001, 3'b001, 3'b001};

        // Reset state
        do_reset();

        // 1. Single read
        req_addr[0 +: AW] = 32'h10;
        req = 3'b001;
        #1;
        check("t1_gnt", gnt, 3'b001);
        check("t1_mem_en", mem_en, 1);
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_mem_we", mem_we, 0);
        check("t1_busy", busy, 1);
        tick();
        req = '0;
        #1;
        check("t1_rvalid", rvalid, 3'b001);
        check("t1_rdata", rdata, 32'hCAFE);
        check("t1_gnt_idle", gnt, 0);
        check("t1_mem_en_idle", mem_en, 0);

        // 2. Contention, requester 2 writes
        do_reset();
        set_addrs();
        req = 3'b111;
        req_we = 3'b100;
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t2_gnt", gnt, one_hot(exp2[k]));
            check("t2_mem_addr", mem_addr, addr_of(exp2[k]));
            check("t2_mem_we", mem_we, (exp2[k] == 2));
            if (exp2[k] == 2) check("t2_wdata", mem_wdata, 32'hD00D_0002);
            if (prev >= 0) begin
                check("t2_rvalid", rvalid, (prev == 2) ? 3'b000 : one_hot(prev));
                if (prev != 2) check("t2_rdata", rdata, mem_val(addr_of(prev)));
            end
            prev = exp2[k];
            tick();
        end
        req = '0;
        req_we = '0;
        #1;
        check("t2_rvalid_after_write", rvalid, 0);

        // 3. Burst lock limit
        do_reset();
        set_addrs();
        req = 3'b011;
        req_lock = 3'b001;
        for (int k = 0; k < 12; k++) begin
            #1;
            check($sformatf("t3_gnt_c%0d", k), gnt, exp3[k]);
            if (k > 0) check("t3_rvalid", rvalid, exp3[k-1]);
            tick();
        end
        req = '0;
        req_lock = '0;

        // 4. Early unlock, no bubble
        do_reset();
        set_addrs();
        req = 3'b101;
        req_lock = 3'b001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_gnt_locked", gnt, 3'b001);
            tick();
        end
        req_lock = 3'b000;
        #1;
        check("t4_gnt_unlock", gnt, 3'b100);
        check("t4_mem_en", mem_en, 1);
        tick();
        #1;
        check("t4_gnt_rr0", gnt, 3'b001);
        tick();
        #1;
        check("t4_gnt_rr2", gnt, 3'b100);
        tick();
        req = '0;

        // 5. Reset mid-read
        do_reset();
        set_addrs();
        req = 3'b001;
        #1;
        check("t5_gnt", gnt, 3'b001);
        rst_n = 1'b0;
        tick();
        #1;
        check("t5_rvalid_dropped", rvalid, 0);
        check("t5_busy", busy, 0);
        check("t5_gnt_rst", gnt, 0);
        rst_n = 1'b1;
        req = 3'b110;
        #1;
        check("t5_gnt_after", gnt, 3'b010);
        check("t5_rvalid_after", rvalid, 0);
        tick();

        // 6. Idle holds pointer
        req = '0;
        #1;
        check("t6_rvalid", rvalid, 3'b010);
        check("t6_rdata", rdata, mem_val(addr_of(1)));
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            check("t6_gnt", gnt, 0);
            check("t6_mem_en", mem_en, 0);
            check("t6_busy", busy, 0);
            check("t6_mem_addr", mem_addr, 0);
        end
        req = 3'b111;
        #1;
        check("t6_ptr_kept", gnt, 3'b100);
        tick();
        req = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
